// File: rtl/act_pingpong_buffer.sv
// act_pingpong_buffer
// Two-bank activation store between the neuron datapath and the goodness
// calculator. One bank is filled from the valid/ready stream while the other
// is presented in parallel to the calculator. Frames are released by gc_done.
//
// Reader FSM
//   state   | meaning
//   R_IDLE  | waiting for the bank at rd_bank to become full
//   R_START | gc_start asserted for exactly this cycle
//   R_WAIT  | calculator owns bank rd_bank until gc_done
module act_pingpong_buffer #(
  parameter int NUM_NEURONS = 256,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_wr_valid,
  output logic                                   o_wr_ready,
  input  logic [DATA_WIDTH-1:0]                  i_wr_data,
  input  logic                                   i_flush,
  output logic                                   o_gc_start,
  input  logic                                   i_gc_done,
  output logic [0:NUM_NEURONS-1][DATA_WIDTH-1:0] o_act_data,
  output logic [1:0]                             o_frames_ready,
  output logic                                   o_proto_err
);

  localparam int               IDX_W    = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;

  // Storage has no reset; contents are only meaningful once a bank is full.
  logic [0:NUM_NEURONS-1][DATA_WIDTH-1:0] r_bank [0:1];

  logic             r_wr_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [1:0]       r_full;
  logic             r_rd_bank;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_proto_err;

  logic w_accept;
  logic w_last;
  logic w_release;

  // Ready comes from registers only so the producer never sees a loop.
  assign o_wr_ready = ~r_full[r_wr_bank];
  assign w_accept   = i_wr_valid & o_wr_ready & ~i_flush;
  assign w_last     = w_accept & (r_wr_idx == LAST_IDX);
  assign w_release  = (r_state == R_WAIT) & i_gc_done;

  assign o_gc_start     = (r_state == R_START);
  assign o_frames_ready = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign o_act_data     = r_bank[r_rd_bank];
  assign o_proto_err    = r_proto_err;

  // Store each accepted word at its arrival index in the fill bank.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bank[r_wr_bank][r_wr_idx] <= i_wr_data;
    end
  end

  // Fill pointer: flush abandons the partial frame, last word swaps banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
    end else if (i_flush) begin
      r_wr_idx <= '0;
    end else if (w_last) begin
      r_wr_idx  <= '0;
      r_wr_bank <= ~r_wr_bank;
    end else if (w_accept) begin
      r_wr_idx <= r_wr_idx + IDX_W'(1);
    end
  end

  // Full flags: writer sets on frame completion, reader clears on release.
  // The two never target the same bank in one cycle since a full bank is
  // never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      if (w_release) r_full[r_rd_bank] <= 1'b0;
      if (w_last)    r_full[r_wr_bank] <= 1'b1;
    end
  end

  // Reader next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (r_full[r_rd_bank]) w_state_nxt = R_START;
      R_START: w_state_nxt = R_WAIT;
      R_WAIT:  if (i_gc_done) w_state_nxt = R_IDLE;
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // Reader state and read-bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      r_rd_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  // Sticky flag for a done pulse that arrives when nothing is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (i_gc_done && (r_state != R_WAIT)) begin
      r_proto_err <= 1'b1;
    end
  end

endmodule
